// File: rtl/stq_pkg.sv
// Store-queue CAM shared types and ring helpers.
// Byte-mask matching is compiled in when STQ_BMASK_EN is defined.
package stq_pkg;

  typedef enum logic [1:0] {
    FREE,
    ALLOC,
    ADDR,
    PASSE
  } stq_state_e;

  localparam int STQ_BMASK_W = 16;
  localparam int STQ_HALF_W  = STQ_BMASK_W / 2;

  function automatic int ring_add(int ptr, int k, int n);
    return (ptr + k) % n;
  endfunction

  function automatic logic is_live(stq_state_e s);
    return (s == ALLOC) || (s == ADDR);
  endfunction

endpackage

// File: rtl/stq_cam_entry.sv
// One store-queue entry: lifecycle FSM, address halves and check comparators.
// STQ_BMASK_EN adds a 16-bit byte mask that must overlap for a hit.
module stq_cam_entry
  import stq_pkg::*;
#(
  parameter int AW        = 36,
  parameter int CHK_PORTS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc,
  input  logic                    wr,
  input  logic                    upd_set,
  input  logic                    passe_set,
  input  logic                    drain,
  input  logic [AW-1:0]           wr_addrE,
  input  logic [AW-1:0]           wr_addrO,
`ifdef STQ_BMASK_EN
  input  logic [STQ_BMASK_W-1:0]  wr_bmask,
  input  logic [CHK_PORTS*STQ_BMASK_W-1:0] chk_bmask,
`endif
  input  logic [CHK_PORTS-1:0]    chk_en,
  input  logic [CHK_PORTS*AW-1:0] chk_addrE,
  input  logic [CHK_PORTS*AW-1:0] chk_addrO,
  output stq_state_e              state,
  output logic                    upd,
  output logic [CHK_PORTS-1:0]    hit_e,
  output logic [CHK_PORTS-1:0]    hit_o
);

  stq_state_e state_q, state_d;
  logic upd_q, upd_d;
  logic [AW-1:0] addr_e, addr_o;
`ifdef STQ_BMASK_EN
  logic [STQ_BMASK_W-1:0] bmask;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q   <= upd_d;
    end
  end

  // Flush discards only unretired entries; PASSE waits for drain.
  always_comb begin
    state_d = state_q;
    upd_d   = upd_q;
    unique case (state_q)
      FREE:  if (alloc && !flush) state_d = ALLOC;
      ALLOC: begin
        if (flush)   state_d = FREE;
        else if (wr) state_d = ADDR;
      end
      ADDR: begin
        if (flush)          state_d = FREE;
        else if (passe_set) state_d = PASSE;
      end
      PASSE: if (drain) state_d = FREE;
      default: state_d = FREE;
    endcase
    if (state_d == FREE || state_d == PASSE)
      upd_d = 1'b0;
    else if (upd_set && !flush && is_live(state_q))
      upd_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state_q == ALLOC && wr && !flush) begin
      addr_e <= wr_addrE;
      addr_o <= wr_addrO;
`ifdef STQ_BMASK_EN
      bmask  <= wr_bmask;
`endif
    end
  end

  always_comb begin
    hit_e = '0;
    hit_o = '0;
    for (int p = 0; p < CHK_PORTS; p++) begin
      hit_e[p] = chk_en[p] && state_q == ADDR &&
                 addr_e == chk_addrE[p*AW +: AW];
      hit_o[p] = chk_en[p] && state_q == ADDR &&
                 addr_o == chk_addrO[p*AW +: AW];
`ifdef STQ_BMASK_EN
      hit_e[p] = hit_e[p] && |(bmask[STQ_HALF_W-1:0] &
                 chk_bmask[p*STQ_BMASK_W +: STQ_HALF_W]);
      hit_o[p] = hit_o[p] && |(bmask[STQ_BMASK_W-1:STQ_HALF_W] &
                 chk_bmask[p*STQ_BMASK_W+STQ_HALF_W +: STQ_HALF_W]);
`endif
    end
  end

  assign state = state_q;
  assign upd   = upd_q;

endmodule

// File: rtl/stq_addr_cam.sv
// Store-queue address CAM: ring pointers, occupancy and per-entry CAM array.
// Define STQ_BMASK_EN to add wr_bmask/chk_bmask byte-mask qualification.
module stq_addr_cam
  import stq_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int AW        = 36,
  parameter int WR_PORTS  = 2,
  parameter int CHK_PORTS = 6,
  parameter int IDXW      = $clog2(ENTRIES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            excpt,
  input  logic [WR_PORTS-1:0]             alloc_req,
  output logic [WR_PORTS*IDXW-1:0]        alloc_idx,
  output logic                            alloc_ok,
  input  logic [WR_PORTS-1:0]             wr_en,
  input  logic [WR_PORTS*IDXW-1:0]        wr_idx,
  input  logic [WR_PORTS*AW-1:0]          wr_addrE,
  input  logic [WR_PORTS*AW-1:0]          wr_addrO,
`ifdef STQ_BMASK_EN
  input  logic [WR_PORTS*STQ_BMASK_W-1:0] wr_bmask,
  input  logic [CHK_PORTS*STQ_BMASK_W-1:0] chk_bmask,
`endif
  input  logic [ENTRIES-1:0]              upd_en,
  input  logic [ENTRIES-1:0]              passe_en,
  input  logic                            drain_en,
  input  logic [CHK_PORTS-1:0]            chk_en,
  input  logic [CHK_PORTS*AW-1:0]         chk_addrE,
  input  logic [CHK_PORTS*AW-1:0]         chk_addrO,
  output logic [CHK_PORTS*ENTRIES*2-1:0]  chk_match,
  output logic [ENTRIES-1:0]              upd,
  output logic [ENTRIES-1:0]              passe,
  output logic [IDXW:0]                   count
);

  localparam int CW = IDXW + 1;

  stq_state_e st [ENTRIES];
  logic [IDXW-1:0] head, tail;
  logic [CW-1:0] npasse, n_alloc, n_passe;
  logic [WR_PORTS-1:0] alloc_fire;
  logic [ENTRIES-1:0] passe_fire;
  logic drain_fire;

  assign alloc_ok   = (ENTRIES - int'(count)) >= WR_PORTS;
  assign alloc_fire = alloc_req & {WR_PORTS{alloc_ok & ~excpt}};
  assign drain_fire = drain_en && (st[head] == PASSE);

  for (genvar k = 0; k < WR_PORTS; k++) begin : g_aidx
    assign alloc_idx[k*IDXW +: IDXW] =
      IDXW'(ring_add(int'(tail), k, ENTRIES));
  end

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < WR_PORTS; k++)
      n_alloc += CW'(alloc_fire[k]);
    n_passe = '0;
    for (int e = 0; e < ENTRIES; e++)
      n_passe += CW'(passe_fire[e]);
  end

  // Retired entries sit contiguously from head, so a flush rewinds
  // the tail to just past them.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      npasse <= '0;
    end else begin
      head   <= head + IDXW'(drain_fire);
      npasse <= npasse + n_passe - CW'(drain_fire);
      if (excpt) begin
        tail  <= head + npasse[IDXW-1:0];
        count <= npasse - CW'(drain_fire);
      end else begin
        tail  <= tail + n_alloc[IDXW-1:0];
        count <= count + n_alloc - CW'(drain_fire);
      end
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    logic al, wv;
    logic [AW-1:0] ae, ao;
    logic [CHK_PORTS-1:0] he, ho;
`ifdef STQ_BMASK_EN
    logic [STQ_BMASK_W-1:0] bm;
`endif

    always_comb begin
      al = 1'b0;
      for (int k = 0; k < WR_PORTS; k++)
        if (alloc_fire[k] && alloc_idx[k*IDXW +: IDXW] == IDXW'(e))
          al = 1'b1;
    end

    // Ascending scan: the highest-numbered matching port wins.
    always_comb begin
      wv = 1'b0;
      ae = '0;
      ao = '0;
`ifdef STQ_BMASK_EN
      bm = '0;
`endif
      for (int p = 0; p < WR_PORTS; p++)
        if (wr_en[p] && wr_idx[p*IDXW +: IDXW] == IDXW'(e)) begin
          wv = 1'b1;
          ae = wr_addrE[p*AW +: AW];
          ao = wr_addrO[p*AW +: AW];
`ifdef STQ_BMASK_EN
          bm = wr_bmask[p*STQ_BMASK_W +: STQ_BMASK_W];
`endif
        end
    end

    assign passe_fire[e] = passe_en[e] && st[e] == ADDR && !excpt;
    assign passe[e]      = st[e] == PASSE;

    stq_cam_entry #(
      .AW(AW),
      .CHK_PORTS(CHK_PORTS)
    ) u_ent (
      .clk(clk),
      .rst(rst),
      .flush(excpt),
      .alloc(al),
      .wr(wv),
      .upd_set(upd_en[e]),
      .passe_set(passe_en[e]),
      .drain(drain_fire && head == IDXW'(e)),
      .wr_addrE(ae),
      .wr_addrO(ao),
`ifdef STQ_BMASK_EN
      .wr_bmask(bm),
      .chk_bmask(chk_bmask),
`endif
      .chk_en(chk_en),
      .chk_addrE(chk_addrE),
      .chk_addrO(chk_addrO),
      .state(st[e]),
      .upd(upd[e]),
      .hit_e(he),
      .hit_o(ho)
    );

    for (genvar p = 0; p < CHK_PORTS; p++) begin : g_hit
      assign chk_match[(p*ENTRIES+e)*2]   = he[p];
      assign chk_match[(p*ENTRIES+e)*2+1] = ho[p];
    end
  end

endmodule

// File: tb/tb_stq_addr_cam.sv
// Scoreboard bench for stq_addr_cam: directed scenarios then random traffic
// against an entry-array reference model (default build, no byte masks).
module tb_stq_addr_cam;

  localparam int NE = 64;
  localparam int AW = 36;
  localparam int WP = 2;
  localparam int CP = 6;
  localparam int IW = 6;

  logic clk;
  logic rst, excpt, drain_en;
  logic [WP-1:0] alloc_req, wr_en;
  logic [WP*IW-1:0] wr_idx, alloc_idx;
  logic [WP*AW-1:0] wr_addrE, wr_addrO;
  logic [NE-1:0] upd_en, passe_en, upd, passe;
  logic [CP-1:0] chk_en;
  logic [CP*AW-1:0] chk_addrE, chk_addrO;
  logic [CP*NE*2-1:0] chk_match;
  logic alloc_ok;
  logic [IW:0] count;

  stq_addr_cam dut (
    .clk(clk), .rst(rst), .excpt(excpt),
    .alloc_req(alloc_req), .alloc_idx(alloc_idx), .alloc_ok(alloc_ok),
    .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_addrE(wr_addrE), .wr_addrO(wr_addrO),
    .upd_en(upd_en), .passe_en(passe_en), .drain_en(drain_en),
    .chk_en(chk_en), .chk_addrE(chk_addrE), .chk_addrO(chk_addrO),
    .chk_match(chk_match), .upd(upd), .passe(passe), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WP*IW-1:0] ai;
    logic ok;
    logic [IW:0] cnt;
    logic [NE-1:0] up;
    logic [NE-1:0] pa;
    logic [CP*NE*2-1:0] cm;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Reference model: 0 free, 1 allocated, 2 address known, 3 retired.
  int ms [NE];
  bit mup [NE];
  logic [AW-1:0] mae [NE];
  logic [AW-1:0] mao [NE];
  int mhead;

  function automatic int m_count();
    int c = 0;
    for (int e = 0; e < NE; e++) if (ms[e] != 0) c++;
    return c;
  endfunction

  function automatic int m_npasse();
    int c = 0;
    for (int e = 0; e < NE; e++) if (ms[e] == 3) c++;
    return c;
  endfunction

  function automatic exp_t build_exp();
    exp_t x;
    int cnt = m_count();
    int tl = (mhead + cnt) % NE;
    x.cnt = 7'(cnt);
    x.ok = (NE - cnt) >= WP;
    for (int k = 0; k < WP; k++) x.ai[k*IW +: IW] = 6'((tl + k) % NE);
    for (int e = 0; e < NE; e++) begin
      x.up[e] = mup[e];
      x.pa[e] = (ms[e] == 3);
    end
    x.cm = '0;
    for (int p = 0; p < CP; p++)
      for (int e = 0; e < NE; e++)
        if (chk_en[p] && ms[e] == 2) begin
          x.cm[(p*NE+e)*2]   = (mae[e] == chk_addrE[p*AW +: AW]);
          x.cm[(p*NE+e)*2+1] = (mao[e] == chk_addrO[p*AW +: AW]);
        end
    return x;
  endfunction

  function automatic void model_step();
    int os [NE];
    int cnt, tl;
    bit dr;
    if (rst) begin
      for (int e = 0; e < NE; e++) begin
        ms[e] = 0;
        mup[e] = 0;
      end
      mhead = 0;
      return;
    end
    os = ms;
    cnt = m_count();
    tl = (mhead + cnt) % NE;
    dr = drain_en && os[mhead] == 3;
    if (excpt) begin
      for (int e = 0; e < NE; e++)
        if (os[e] == 1 || os[e] == 2) begin
          ms[e] = 0;
          mup[e] = 0;
        end
    end else begin
      for (int e = 0; e < NE; e++) begin
        for (int p = 0; p < WP; p++)
          if (wr_en[p] && int'(wr_idx[p*IW +: IW]) == e && os[e] == 1) begin
            ms[e] = 2;
            mae[e] = wr_addrE[p*AW +: AW];
            mao[e] = wr_addrO[p*AW +: AW];
          end
        if (upd_en[e] && (os[e] == 1 || os[e] == 2)) mup[e] = 1;
        if (passe_en[e] && os[e] == 2) begin
          ms[e] = 3;
          mup[e] = 0;
        end
      end
      if (NE - cnt >= WP)
        for (int k = 0; k < WP; k++)
          if (alloc_req[k]) ms[(tl + k) % NE] = 1;
    end
    if (dr) begin
      ms[mhead] = 0;
      mup[mhead] = 0;
      mhead = (mhead + 1) % NE;
    end
  endfunction

  task automatic check(string n, logic [CP*NE*2-1:0] a,
                       logic [CP*NE*2-1:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("alloc_idx", 768'(alloc_idx), 768'(x.ai));
        check("alloc_ok", 768'(alloc_ok), 768'(x.ok));
        check("count", 768'(count), 768'(x.cnt));
        check("upd", 768'(upd), 768'(x.up));
        check("passe", 768'(passe), 768'(x.pa));
        check("chk_match", chk_match, x.cm);
      end
    end
  end

  task automatic clear();
    rst = 0; excpt = 0; drain_en = 0;
    alloc_req = '0; wr_en = '0; wr_idx = '0;
    wr_addrE = '0; wr_addrO = '0;
    upd_en = '0; passe_en = '0;
    chk_en = '0; chk_addrE = '0; chk_addrO = '0;
  endtask

  task automatic step(bit chk);
    if (chk) q.push_back(build_exp());
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] raddr();
    return 36'h0A0 + 36'($urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    int cnt, np, ix;
    clear();
    cnt = m_count();
    excpt = ($urandom_range(0, 23) == 0);
    case ($urandom_range(0, 2))
      0: alloc_req = 2'b00;
      1: alloc_req = 2'b01;
      default: alloc_req = 2'b11;
    endcase
    wr_en = 2'($urandom_range(0, 3));
    for (int p = 0; p < WP; p++) begin
      if ($urandom_range(0, 3) != 0)
        wr_idx[p*IW +: IW] =
          6'((mhead + $urandom_range(0, cnt > 0 ? cnt - 1 : 0)) % NE);
      else
        wr_idx[p*IW +: IW] = 6'($urandom_range(0, NE - 1));
      wr_addrE[p*AW +: AW] = raddr();
      wr_addrO[p*AW +: AW] = raddr();
    end
    if ($urandom_range(0, 3) == 0) wr_idx[IW +: IW] = wr_idx[0 +: IW];
    if ($urandom_range(0, 1) == 1) upd_en[$urandom_range(0, NE - 1)] = 1'b1;
    np = m_npasse();
    ix = (mhead + np) % NE;
    if ($urandom_range(0, 1) == 1 && ms[ix] == 2) begin
      passe_en[ix] = 1'b1;
      if (ms[(ix + 1) % NE] == 2 && $urandom_range(0, 1) == 1)
        passe_en[(ix + 1) % NE] = 1'b1;
    end
    ix = $urandom_range(0, NE - 1);
    if (ms[ix] < 2 && $urandom_range(0, 3) == 0) passe_en[ix] = 1'b1;
    drain_en = ($urandom_range(0, 2) == 0);
    chk_en = 6'($urandom_range(0, 63));
    for (int p = 0; p < CP; p++) begin
      chk_addrE[p*AW +: AW] = raddr();
      chk_addrO[p*AW +: AW] = raddr();
    end
  endtask

  initial begin
    clear();
    rst = 1;
    step(0);
    step(1);
    rst = 0;

    alloc_req = 2'b11;
    step(1);
    clear();
    step(1);

    wr_en = 2'b01;
    wr_idx = '0;
    wr_addrE[AW-1:0] = 36'h123;
    wr_addrO[AW-1:0] = 36'h456;
    chk_en = 6'b000001;
    chk_addrE[AW-1:0] = 36'h123;
    step(1);
    clear();
    chk_en = 6'b000001;
    chk_addrE[AW-1:0] = 36'h123;
    step(1);
    passe_en[0] = 1'b1;
    step(1);
    passe_en = '0;
    step(1);

    clear();
    while (m_count() < 62) begin
      alloc_req = 2'b11;
      step(1);
    end
    alloc_req = 2'b01;
    step(1);
    alloc_req = 2'b11;
    step(1);
    clear();
    drain_en = 1;
    step(1);
    clear();
    step(1);

    rst = 1;
    step(1);
    clear();
    for (int i = 0; i < 5; i++) begin
      alloc_req = 2'b11;
      step(1);
    end
    clear();
    for (int i = 0; i < 5; i++) begin
      wr_en = 2'b11;
      wr_idx = {6'(2*i+1), 6'(2*i)};
      wr_addrE = {36'h200 + 36'(i), 36'h100 + 36'(i)};
      wr_addrO = {36'h400 + 36'(i), 36'h300 + 36'(i)};
      step(1);
    end
    clear();
    passe_en[3:0] = 4'hF;
    step(1);
    clear();
    excpt = 1;
    alloc_req = 2'b11;
    wr_en = 2'b01;
    wr_idx = 12'd5;
    upd_en[6] = 1'b1;
    step(1);
    clear();
    step(1);
    alloc_req = 2'b11;
    step(1);
    clear();
    step(1);

    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      if (i == 1500) rst = 1;
      step(1);
    end
    clear();
    step(0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
